// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  cpu_pkg
//  Shared pipeline types and constants for the MEM stage.
//  Revision: 1.0
// ============================================================================
package cpu_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    localparam logic [31:0] POISON_DATA       = 32'hDEAD_BEEF;
    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'hFFFF_0000;

endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  mem_stage_if
//  Single-outstanding request/acknowledge data bus between MEM stage and memory.
//  Revision: 1.0
// ============================================================================
interface mem_stage_if;

    logic        bus_req;
    logic        bus_we;
    logic        bus_mmio;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_mmio,
        output bus_addr,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_mmio,
        input  bus_addr,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  mem_stage
//  Pipeline MEM stage: bus loads/stores with timeout, MEM/WB register, stall.
//  Revision: 1.0
// ============================================================================
module mem_stage
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] MMIO_BASE      = DEFAULT_MMIO_BASE
) (
    input  wire               clk,
    input  wire               rst_n,

    input  wire               EX_MEM_valid,
    input  wire               EX_MEM_regWrite,
    input  wire               EX_MEM_memRead,
    input  wire               EX_MEM_memWrite,
    input  wire  [4:0]        EX_MEM_rd,
    input  wire  [31:0]       EX_MEM_aluRes,
    input  wire  [31:0]       EX_MEM_storeData,

    mem_stage_if.master       bus,

    output logic              stall,
    output logic              MEM_WB_regWrite,
    output logic [4:0]        MEM_WB_rd,
    output logic [31:0]       MEM_WB_data,
    output logic              err_timeout,
    output logic              err_misalign
);

    localparam int unsigned      CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_bus_req, w_bus_req_nxt;
    logic             r_bus_we, w_bus_we_nxt;
    logic             r_bus_mmio, w_bus_mmio_nxt;
    logic [31:0]      r_bus_addr, w_bus_addr_nxt;
    logic [31:0]      r_bus_wdata, w_bus_wdata_nxt;
    logic             r_wb_rw, w_wb_rw_nxt;
    logic [4:0]       r_wb_rd, w_wb_rd_nxt;
    logic [31:0]      r_wb_data, w_wb_data_nxt;
    logic             r_err_to, w_err_to_nxt;
    logic             r_err_mis, w_err_mis_nxt;

    logic             w_mem_op;
    logic             w_misalign;
    logic             w_ack;
    logic             w_timeout_hit;

    always_comb begin
        w_mem_op      = EX_MEM_valid & (EX_MEM_memRead | EX_MEM_memWrite);
        w_misalign    = (EX_MEM_aluRes[1:0] != 2'b00);
        // In BUSY the request is always asserted, so an ack here is a real one.
        w_ack         = (r_state == BUSY) & bus.bus_ack;
        w_timeout_hit = (r_state == BUSY) & ~bus.bus_ack & (r_cnt == C_CNT_LAST);

        stall = w_mem_op
              & ~((r_state == BUSY) & (w_ack | w_timeout_hit))
              & ~((r_state == IDLE) & w_misalign);

        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_bus_req_nxt   = r_bus_req;
        w_bus_we_nxt    = r_bus_we;
        w_bus_mmio_nxt  = r_bus_mmio;
        w_bus_addr_nxt  = r_bus_addr;
        w_bus_wdata_nxt = r_bus_wdata;
        w_wb_rw_nxt     = r_wb_rw;
        w_wb_rd_nxt     = r_wb_rd;
        w_wb_data_nxt   = r_wb_data;
        w_err_to_nxt    = r_err_to;
        w_err_mis_nxt   = r_err_mis;

        case (r_state)
            IDLE: begin
                if (w_mem_op && w_misalign) begin
                    w_err_mis_nxt = 1'b1;
                    w_wb_rw_nxt   = EX_MEM_regWrite & EX_MEM_memRead;
                    w_wb_rd_nxt   = EX_MEM_rd;
                    w_wb_data_nxt = 32'd0;
                end else if (w_mem_op) begin
                    w_state_nxt     = BUSY;
                    w_cnt_nxt       = '0;
                    w_bus_req_nxt   = 1'b1;
                    w_bus_we_nxt    = EX_MEM_memWrite;
                    w_bus_addr_nxt  = EX_MEM_aluRes;
                    w_bus_wdata_nxt = EX_MEM_storeData;
                    w_bus_mmio_nxt  = (EX_MEM_aluRes >= MMIO_BASE);
                end else if (EX_MEM_valid) begin
                    w_wb_rw_nxt   = EX_MEM_regWrite;
                    w_wb_rd_nxt   = EX_MEM_rd;
                    w_wb_data_nxt = EX_MEM_aluRes;
                end else begin
                    w_wb_rw_nxt = 1'b0;
                end
            end
            BUSY: begin
                // EX/MEM is frozen by stall, so its fields still describe this access.
                if (w_ack || w_timeout_hit) begin
                    w_state_nxt   = IDLE;
                    w_bus_req_nxt = 1'b0;
                    w_wb_rw_nxt   = EX_MEM_regWrite & EX_MEM_memRead;
                    w_wb_rd_nxt   = EX_MEM_rd;
                    w_wb_data_nxt = w_ack ? bus.bus_rdata : POISON_DATA;
                    if (!w_ack) begin
                        w_err_to_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_mmio  <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_wdata <= 32'd0;
            r_wb_rw     <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_wb_data   <= 32'd0;
            r_err_to    <= 1'b0;
            r_err_mis   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bus_req   <= w_bus_req_nxt;
            r_bus_we    <= w_bus_we_nxt;
            r_bus_mmio  <= w_bus_mmio_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_bus_wdata <= w_bus_wdata_nxt;
            r_wb_rw     <= w_wb_rw_nxt;
            r_wb_rd     <= w_wb_rd_nxt;
            r_wb_data   <= w_wb_data_nxt;
            r_err_to    <= w_err_to_nxt;
            r_err_mis   <= w_err_mis_nxt;
        end
    end

    assign bus.bus_req    = r_bus_req;
    assign bus.bus_we     = r_bus_we;
    assign bus.bus_mmio   = r_bus_mmio;
    assign bus.bus_addr   = r_bus_addr;
    assign bus.bus_wdata  = r_bus_wdata;
    assign MEM_WB_regWrite = r_wb_rw;
    assign MEM_WB_rd       = r_wb_rd;
    assign MEM_WB_data     = r_wb_data;
    assign err_timeout     = r_err_to;
    assign err_misalign    = r_err_mis;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  tb_mem_stage
//  Directed and randomized checks of mem_stage against a transaction-level model.
//  Revision: 1.0
// ============================================================================
module tb_mem_stage;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0, ex_rw = 1'b0, ex_mr = 1'b0, ex_mw = 1'b0;
    logic [4:0]  ex_rd = 5'd0;
    logic [31:0] ex_alu = 32'd0, ex_sd = 32'd0;
    logic        stall, wb_rw, err_to, err_mis;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int total = 0;
    int bad   = 0;

    mem_stage_if bus_if ();

    mem_stage #(.TIMEOUT_CYCLES(TO), .MMIO_BASE(32'hFFFF_0000)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .EX_MEM_valid     (ex_valid),
        .EX_MEM_regWrite  (ex_rw),
        .EX_MEM_memRead   (ex_mr),
        .EX_MEM_memWrite  (ex_mw),
        .EX_MEM_rd        (ex_rd),
        .EX_MEM_aluRes    (ex_alu),
        .EX_MEM_storeData (ex_sd),
        .bus              (bus_if),
        .stall            (stall),
        .MEM_WB_regWrite  (wb_rw),
        .MEM_WB_rd        (wb_rd),
        .MEM_WB_data      (wb_data),
        .err_timeout      (err_to),
        .err_misalign     (err_mis)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one pending transaction plus the architectural results it must produce.
    logic        m_busy, m_we, m_mmio, m_last_stall;
    logic [31:0] m_addr, m_wdata;
    int          m_wait;
    logic        p_rw, p_load;
    logic [4:0]  p_rd;
    logic        m_wb_rw, m_err_to, m_err_mis;
    logic [4:0]  m_wb_rd;
    logic [31:0] m_wb_data;

    task automatic model_reset();
        m_busy = 0; m_we = 0; m_mmio = 0; m_addr = 0; m_wdata = 0; m_wait = 0;
        p_rw = 0; p_load = 0; p_rd = 0;
        m_wb_rw = 0; m_wb_rd = 0; m_wb_data = 0; m_err_to = 0; m_err_mis = 0;
    endtask

    initial begin
        model_reset();
        m_last_stall = 0;
    end

    always @(negedge clk) begin
        logic mem_op, exp_stall;
        #2;
        if (!rst_n) model_reset();
        mem_op = ex_valid && (ex_mr || ex_mw);
        if (!m_busy) exp_stall = mem_op && (ex_alu[1:0] == 2'b00);
        else         exp_stall = mem_op && !(bus_if.bus_ack || (m_wait + 1 == TO));
        chk("stall", 128'(stall), 128'(exp_stall));
        chk("bus", 128'({bus_if.bus_req, bus_if.bus_we, bus_if.bus_mmio, bus_if.bus_addr, bus_if.bus_wdata}),
                   128'({m_busy, m_we, m_mmio, m_addr, m_wdata}));
        chk("memwb", 128'({wb_rw, wb_rd, wb_data}), 128'({m_wb_rw, m_wb_rd, m_wb_data}));
        chk("errs", 128'({err_to, err_mis}), 128'({m_err_to, m_err_mis}));
        m_last_stall = exp_stall;
        if (rst_n) begin
            if (m_busy) begin
                if (bus_if.bus_ack || (m_wait + 1 == TO)) begin
                    m_busy    = 0;
                    m_wb_rw   = p_rw && p_load;
                    m_wb_rd   = p_rd;
                    m_wb_data = bus_if.bus_ack ? bus_if.bus_rdata : 32'hDEAD_BEEF;
                    if (!bus_if.bus_ack) m_err_to = 1;
                end else begin
                    m_wait++;
                end
            end else if (mem_op && ex_alu[1:0] != 2'b00) begin
                m_err_mis = 1;
                m_wb_rw = ex_rw && ex_mr; m_wb_rd = ex_rd; m_wb_data = 32'd0;
            end else if (mem_op) begin
                m_busy = 1; m_wait = 0;
                m_we = ex_mw; m_addr = ex_alu; m_wdata = ex_sd;
                m_mmio = (ex_alu >= 32'hFFFF_0000);
                p_rw = ex_rw; p_load = ex_mr; p_rd = ex_rd;
            end else if (ex_valid) begin
                m_wb_rw = ex_rw; m_wb_rd = ex_rd; m_wb_data = ex_alu;
            end else begin
                m_wb_rw = 0;
            end
        end
    end

    task automatic tick(input logic v, rw, mr, mw, input logic [4:0] rd,
                        input logic [31:0] alu, sd, input logic ack, input logic [31:0] rdata);
        @(negedge clk);
        ex_valid = v; ex_rw = rw; ex_mr = mr; ex_mw = mw;
        ex_rd = rd; ex_alu = alu; ex_sd = sd;
        bus_if.bus_ack = ack; bus_if.bus_rdata = rdata;
        #1;
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    endtask

    // Launch one access and hold it until it must complete (ack at BUSY cycle delay, or timeout).
    task automatic access(input logic rw, mr, mw, input logic [4:0] rd, input logic [31:0] addr, sd,
                          input int delay, input logic [31:0] rdata, output int busy, output logic mmio_seen);
        int last;
        last = (delay < TO - 1) ? delay : TO - 1;
        tick(1'b1, rw, mr, mw, rd, addr, sd, 1'b0, 32'd0);
        chk("launch_stall", 128'(stall), 128'(1'b1));
        busy = 0; mmio_seen = 0;
        for (int i = 0; i <= last; i++) begin
            tick(1'b1, rw, mr, mw, rd, addr, sd, (i == delay), (i == delay) ? rdata : 32'd0);
            if (bus_if.bus_req) busy++;
            mmio_seen |= bus_if.bus_mmio;
            chk("busy_addr", 128'({bus_if.bus_addr, bus_if.bus_we, bus_if.bus_wdata}), 128'({addr, mw, sd}));
            chk("busy_stall", 128'(stall), 128'(i != last));
        end
    endtask

    initial begin
        int   busy;
        logic mmio;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'd0;
        idle();
        chk("reset_state", 128'({bus_if.bus_req, bus_if.bus_addr, wb_rw, wb_rd, wb_data, err_to, err_mis}), 128'd0);
        idle();
        @(negedge clk) rst_n = 1'b1;

        tick(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h0000_0042, 32'd0, 1'b0, 32'd0);
        chk("alu_stall", 128'(stall), 128'(1'b0));
        access(1'b1, 1'b1, 1'b0, 5'd8, 32'h0000_0100, 32'd0, 3, 32'hCAFE_F00D, busy, mmio);
        chk("load_req_cycles", 128'(busy), 128'(4));
        chk("wb_held", 128'({wb_rw, wb_rd, wb_data}), 128'({1'b1, 5'd5, 32'h42}));
        idle();
        chk("load_wb", 128'({wb_rw, wb_rd, wb_data}), 128'({1'b1, 5'd8, 32'hCAFE_F00D}));

        access(1'b1, 1'b0, 1'b1, 5'd3, 32'hFFFF_0004, 32'h55, 1, 32'd0, busy, mmio);
        chk("store_mmio", 128'(mmio), 128'(1'b1));
        idle();
        chk("store_no_wb", 128'(wb_rw), 128'(1'b0));

        access(1'b1, 1'b1, 1'b0, 5'd12, 32'h0000_0300, 32'd0, TO - 1, 32'h1234_5678, busy, mmio);
        chk("late_ack_cycles", 128'(busy), 128'(TO));
        idle();
        chk("late_ack_wb", 128'({wb_rw, wb_rd, wb_data, err_to}), 128'({1'b1, 5'd12, 32'h1234_5678, 1'b0}));

        tick(1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h0000_0102, 32'd0, 1'b0, 32'd0);
        chk("mis_stall", 128'({stall, bus_if.bus_req}), 128'd0);
        idle();
        chk("mis_wb", 128'({wb_rw, wb_rd, wb_data, err_mis, bus_if.bus_req}), 128'({1'b1, 5'd9, 32'd0, 1'b1, 1'b0}));

        access(1'b1, 1'b1, 1'b0, 5'd10, 32'h0000_0200, 32'd0, 1000, 32'd0, busy, mmio);
        chk("timeout_cycles", 128'(busy), 128'(8));
        tick(1'b1, 1'b1, 1'b0, 1'b0, 5'd11, 32'h77, 32'd0, 1'b0, 32'd0);
        chk("timeout_wb", 128'({wb_rw, wb_rd, wb_data, err_to}), 128'({1'b1, 5'd10, 32'hDEAD_BEEF, 1'b1}));
        idle();
        chk("after_timeout", 128'({wb_rw, wb_rd, wb_data, err_to}), 128'({1'b1, 5'd11, 32'h77, 1'b1}));

        tick(1'b1, 1'b1, 1'b1, 1'b0, 5'd13, 32'h0000_0400, 32'd0, 1'b0, 32'd0);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 5'd13, 32'h0000_0400, 32'd0, 1'b0, 32'd0);
        @(negedge clk) rst_n = 1'b0;
        #1 chk("reset_mid", 128'({bus_if.bus_req, bus_if.bus_addr, wb_rw, wb_data, err_to, err_mis}), 128'd0);
        @(negedge clk);
        rst_n = 1'b1; ex_valid = 1'b0; bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hBAD0_BAD0;
        idle();
        chk("late_ack_ignored", 128'({bus_if.bus_req, wb_rw, wb_data}), 128'd0);

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (!m_last_stall) begin
                int unsigned kind;
                logic [31:0] a;
                kind = $urandom_range(0, 9);
                a = $urandom;
                if ($urandom_range(0, 3) == 0) a = 32'hFFFF_0000 | (a & 32'h0000_FFFF);
                if ($urandom_range(0, 9) != 0) a = a & 32'hFFFF_FFFC;
                ex_valid = (kind >= 2);
                ex_rw    = (kind != 8) && (kind != 9) ? 1'b1 : logic'($urandom_range(0, 1));
                ex_mr    = (kind >= 5) && (kind <= 7);
                ex_mw    = (kind >= 8);
                ex_rd    = 5'($urandom);
                ex_alu   = (kind >= 5) ? a : $urandom;
                ex_sd    = $urandom;
            end
            bus_if.bus_ack   = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
            bus_if.bus_rdata = $urandom;
        end

        idle();
        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Pipeline MEM stage: consumes the EX/MEM register, runs loads/stores on a single-outstanding request/acknowledge data bus (RAM or MMIO), and owns the MEM/WB register. Its MEM/WB outputs feed writeback and the EX-stage forwarding unit. It stalls upstream stages while a bus access is outstanding, and aborts hung accesses with a timeout.

## Interface
- `TIMEOUT_CYCLES`, 255: cycles `bus_req` may wait for `bus_ack` before the access is aborted.
- `MMIO_BASE`, 32'hFFFF_0000: addresses >= this value are MMIO.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `EX_MEM_valid` in 1: EX/MEM holds a real instruction.
- `EX_MEM_regWrite`, `EX_MEM_memRead`, `EX_MEM_memWrite` in 1 each: control bits.
- `EX_MEM_rd` in 5: destination register.
- `EX_MEM_aluRes` in 32: ALU result, or effective address for memory ops.
- `EX_MEM_storeData` in 32: store data.
- `bus_req` out 1: request, registered.
- `bus_we` out 1: write, registered.
- `bus_mmio` out 1: address is in the MMIO region, registered.
- `bus_addr` out 32: registered.
- `bus_wdata` out 32: registered.
- `bus_ack` in 1: completes the request this cycle.
- `bus_rdata` in 32: load data, valid with `bus_ack`.
- `stall` out 1: combinational; freezes PC, IF/ID, ID/EX and EX/MEM.
- `MEM_WB_regWrite` out 1, `MEM_WB_rd` out 5, `MEM_WB_data` out 32: MEM/WB register.
- `err_timeout`, `err_misalign` out 1 each: sticky error flags.

## Operation
- FSM states: `IDLE`, `BUSY`.
- Memory op: `EX_MEM_valid & (memRead | memWrite)`.
- Misaligned: `aluRes[1:0] != 0`.
- **IDLE, non-memory valid op:** on the next edge, MEM/WB <= {regWrite, rd, aluRes}.
- **IDLE, invalid op:** on the next edge, MEM_WB_regWrite <= 0.
- **IDLE, aligned memory op:**
  - On the next edge: bus_req <= 1, bus_we <= memWrite, bus_addr <= aluRes, bus_wdata <= storeData, bus_mmio <= (aluRes >= MMIO_BASE), timeout counter <= 0.
  - State -> BUSY. MEM/WB holds its value.
- **IDLE, misaligned memory op:**
  - No bus access; err_misalign <= 1.
  - Completes in one cycle: MEM/WB <= {regWrite & memRead, rd, 32'd0}.
- **BUSY:**
  - Bus outputs are held stable.
  - Counter increments each cycle without `bus_ack`.
  - MEM/WB holds its previous contents (idempotent re-writeback; keeps forwarding to the stalled EX instruction correct).
- **BUSY completion:** `bus_ack`, or counter == TIMEOUT_CYCLES-1 without ack.
  - MEM/WB <= {regWrite & memRead, rd, ack ? bus_rdata : 32'hDEAD_BEEF}.
  - bus_req <= 0; state -> IDLE.
  - err_timeout <= 1 on the timeout path.
- **Stall:**
  - `stall = mem_op & !(state==BUSY & (bus_ack | timeout_hit)) & !(state==IDLE & misaligned)`.
  - So stall is high in the IDLE cycle that launches an aligned access. It is low in the completion cycle.
- **Stores:** `MEM_WB_regWrite` is 0.
- **rd == 0:** passed through unchanged; consumers filter it.
- **Errors:** both flags are sticky until reset.

## Timing
- **Reset values:** state IDLE; bus_req 0; bus_we 0; bus_mmio 0; bus_addr 0; bus_wdata 0; MEM_WB_regWrite 0; MEM_WB_rd 0; MEM_WB_data 0; counter 0; err_timeout 0; err_misalign 0.
- **Reset mid-access:** bus_req drops asynchronously. The access is abandoned and a late `bus_ack` is ignored.
- **Non-memory and misaligned ops:** 1-cycle latency EX/MEM -> MEM/WB.
- **Aligned memory op, minimum latency:** 2 cycles. Cycle 0 launches; cycle 1 has `bus_req`=1 and `bus_ack`=1; MEM/WB is updated at the end of cycle 1.
- **Back-to-back memory ops:** the next access launches in the cycle after completion (one IDLE cycle between requests).
- **Ack rules:**
  - `bus_ack` while `bus_req`=0 is ignored.
  - `bus_ack` in the same cycle as timeout_hit takes the ack path; no error is flagged.
- **Bus stability:** `bus_addr`, `bus_we`, `bus_wdata` and `bus_mmio` are constant for the whole time `bus_req` is high.

## Structure
- Shared `cpu_pkg` holds:
  - `mem_state_t` enum {IDLE, BUSY}
  - `POISON_DATA` = 32'hDEAD_BEEF
  - default `MMIO_BASE`
- Counter width is `$clog2(TIMEOUT_CYCLES+1)`, local to the module.
- Single module; no sub-module. The FSM, counter and MEM/WB register are small enough to stay flat.

## Test plan
- **ALU pass-through:** add with aluRes=32'h0000_0042, rd=5 -> next edge MEM_WB = {1, 5, 0x42}; stall never high.
- **Load with ack delay 3:** lw rd=8, addr 0x100, rdata=0xCAFE_F00D.
  - bus_req high for 4 cycles; stall high until the ack cycle.
  - MEM_WB_data=0xCAFEF00D, regWrite=1.
  - Upstream MEM/WB contents are held during the stall.
- **Store to MMIO:** sw addr 0xFFFF_0004, data 0x55.
  - bus_we=1, bus_mmio=1, bus_wdata=0x55.
  - After ack, MEM_WB_regWrite=0.
- **Timeout:** load with no ack and TIMEOUT_CYCLES=8.
  - Completion after 8 BUSY cycles; MEM_WB_data=0xDEADBEEF; err_timeout=1 and stays 1.
  - Then an ALU op proceeds normally.
- **Misaligned:** lw addr 0x102 -> bus_req stays 0; stall stays 0; MEM_WB_data=0; err_misalign=1.
- **Reset mid-access:** assert rst_n=0 while BUSY -> bus_req=0 immediately; all outputs at reset values. An ack after release has no effect.
